ft245_sync_tx_streamer: RTL and testbench
=========================================

# ft245_sync_tx_streamer

Parametrised FT245 synchronous-FIFO transmit engine for the FT2232H (CLKOUT domain, 60 MHz). It accepts bytes from an upstream valid/ready source, or generates a free-running count pattern, and buffers them in an internal FWFT FIFO. It drives WR#/OE#/ADBUS so that no byte is lost or duplicated when TXE# deasserts mid-burst. It sits between the DAQ packetiser and the FT2232H pins, and replaces the fixed count-only demo streamer.

## Interface
- DATA_W, 8: bus width; must match the FT device (8 for FT2232H).
- FIFO_DEPTH, 16: internal buffer depth in bytes; power of two, minimum 4.
- BLINK_BIT, 22: index into bytes_sent_o driven onto blinker_o.

Clocking and reset:
- clk_i  in  1  FT2232H CLKOUT; the single clock; all logic on posedge.
- rst_ni  in  1  asynchronous, active-low reset.

Source and configuration:
- mode_i  in  1  0 = stream from s_*; 1 = internal count pattern.
- s_data_i  in  DATA_W  upstream byte.
- s_valid_i  in  1  upstream byte valid.
- s_ready_o  out  1  FIFO can accept; forced 0 when mode_i=1.

FT2232H pins:
- adbus_io  inout  DATA_W  ADBUS; driven only in ARM/WRITE/HOLD, else Z.
- txe_i  in  1  TXE#, active-low; FT can accept data.
- wr_o  out  1  WR#, active-low write strobe.
- oe_o  out  1  OE#; held 1, so the FT never drives the bus.

Status:
- level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- bytes_sent_o  out  32  count of bytes accepted by the FT; wraps.
- blinker_o  out  1  bytes_sent_o[BLINK_BIT].

## Operation
- Reset values:
  - state IDLE
  - wr_o=1, oe_o=1, adbus_io=Z
  - FIFO empty, level_o=0, s_ready_o=0 during reset
  - bytes_sent_o=0, pattern counter=0
- Push rules:
  - mode_i=0: push on s_valid_i & s_ready_o, where s_ready_o = !full.
  - mode_i=1: push the pattern counter every cycle the FIFO is not full; the counter increments (mod 2^DATA_W) on each push.
  - A mode change takes effect at the next edge. Bytes already buffered drain in order. The pattern counter holds its value and is not reset.
- Accept rule (identical to the FT's): a byte is consumed at a rising edge iff wr_o==0 and txe_i==0 at that edge. On accept: pop FIFO, bytes_sent_o += 1.
- adbus_io always presents the FIFO head (FWFT) while driven. The head changes only on accept.
- A simultaneous push and pop leaves level_o unchanged. A push into a full FIFO cannot occur (ready low). A pop from an empty FIFO cannot occur (wr_o high in IDLE).
- State machine (all transitions on posedge):
  - IDLE: wr_o=1, bus Z. Go to ARM if FIFO non-empty and txe_i=0.
  - ARM: bus driven with head, wr_o=1; one-cycle bus turnaround. Go to WRITE if txe_i=0, else HOLD.
  - WRITE: wr_o=0. At the edge:
    - if txe_i=1: no accept, go to HOLD with wr_o=1, head retained;
    - else accept; if level after pop = 0, go to IDLE (wr_o=1, release bus);
    - else stay in WRITE.
  - HOLD: wr_o=1, bus driven. Go to WRITE when txe_i=0 while FIFO non-empty. Go to IDLE if FIFO empty (cannot occur from WRITE, kept for safety).
- Unused state encodings go to IDLE with wr_o=1.
- Reset asserted mid-burst: wr_o goes to 1 and the bus releases immediately (asynchronously). FIFO contents are discarded.

## Timing
- All outputs are registered; no combinational path from txe_i to wr_o or adbus_io.
- Latency from push edge E (FIFO empty, txe_i low): ARM from E+1, wr_o low from E+2, first accept at edge E+3.
- Burst throughput is 1 byte/cycle while txe_i stays low and the FIFO stays non-empty.
- TXE# high during WRITE: the unaccepted byte stays on the bus. It is accepted at the first edge after the return to WRITE, with a minimum 1-cycle bubble after txe_i falls.
- level_o and bytes_sent_o update one cycle after the push/accept edge.

## Structure
- Package ft245_pkg holds:
  - the state enum (IDLE, ARM, WRITE, HOLD);
  - constants for TXE#/WR#/OE# active levels;
  - a DATA_W default of 8.
- Sub-module sync_fifo_fwft (DATA_W, DEPTH): push/pop/full/empty/level, head on dout. The FSM, pattern generator, counters and tristate stay in the top level.

## Test plan
- Reset: hold rst_ni=0 with txe_i=0 and s_valid_i=1 → wr_o=1, oe_o=1, adbus_io=Z, s_ready_o=0, bytes_sent_o=0.
- Burst: push 0x10..0x17 with txe_i=0 → wr_o low from 2 cycles after the first push, FT model receives 0x10..0x17 in order, bytes_sent_o=8, level_o returns to 0, bus Z.
- TXE stall: txe_i=1 for 3 cycles on the 4th byte of 0x00..0x07 → FT model receives exactly 0x00..0x07, no duplicate or loss.
- Backpressure: txe_i=1 throughout, push 20 bytes with FIFO_DEPTH=16 → s_ready_o falls after 16 pushes; then txe_i=0 → all 20 bytes delivered in order.
- Count mode: mode_i=1, txe_i=0 for 300 cycles → delivered bytes are 0x00,0x01,…,0xFF,0x00,… contiguous; bytes_sent_o=0x0000_0010 after 16 accepts with BLINK_BIT=4 sets blinker_o=1.
- Mid-burst reset: rst_ni=0 during WRITE → same-cycle wr_o=1 and bus Z; after release, level_o=0 and no stale byte is sent.

Source files
------------

// File: rtl/ft245_sync_tx_streamer_pkg.sv
// ft245_pkg: shared states, pin active levels and default width for the FT245 sync transmit streamer.
package ft245_pkg;
  localparam int DATA_W_DEF = 8;
  localparam logic TXE_ACTIVE = 1'b0;
  localparam logic WR_ACTIVE = 1'b0;
  localparam logic OE_ACTIVE = 1'b0;
  typedef enum logic [1:0] {IDLE, ARM, WRITE, HOLD} state_e;
endpackage

// File: rtl/ft245_sync_tx_streamer_if.sv
// ft245_sync_tx_streamer_if: upstream valid/ready byte stream feeding the streamer.
interface ft245_sync_tx_streamer_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, output valid, input ready);
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/ft245_sync_tx_streamer_fifo.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO, head always visible on dout_o.
module sync_fifo_fwft
  import ft245_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push_i && !full_o;
    do_pop = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o = level_o == (AW+1)'(DEPTH);
  assign empty_o = level_o == '0;
  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/ft245_sync_tx_streamer.sv
// ft245_sync_tx_streamer: buffers stream or count-pattern bytes and writes them to an FT2232H in FT245 sync mode.
module ft245_sync_tx_streamer
  import ft245_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int BLINK_BIT = 22,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mode_i,
  ft245_sync_tx_streamer_if.slave   s,
  inout  wire  [DATA_W-1:0]         adbus_io,
  input  logic                      txe_i,
  output logic                      wr_o,
  output logic                      oe_o,
  output logic [LW-1:0]             level_o,
  output logic [31:0]               bytes_sent_o,
  output logic                      blinker_o
);
  state_e state_q, state_d;
  logic wr_q, wr_d, drive_q, drive_d;
  logic [31:0] sent_q, sent_d;
  logic [DATA_W-1:0] pat_q, pat_d, push_data, head;
  logic [LW-1:0] lvl_after;
  logic full, empty, push, pop, txe_act;
  sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );
  assign s.ready = rst_ni && !mode_i && !full;
  // The FT consumes a byte exactly when WR# and TXE# are both active at the edge.
  always_comb begin
    txe_act = txe_i == TXE_ACTIVE;
    pop = (wr_q == WR_ACTIVE) && txe_act;
    push = mode_i ? !full : s.valid && s.ready;
    push_data = mode_i ? pat_q : s.data;
    pat_d = pat_q + DATA_W'(mode_i && push);
    sent_d = sent_q + 32'(pop);
    lvl_after = level_o - LW'(pop) + LW'(push);
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = (!empty && txe_act) ? ARM : IDLE;
      ARM:     state_d = txe_act ? WRITE : HOLD;
      WRITE:   state_d = !txe_act ? HOLD : (lvl_after == '0) ? IDLE : WRITE;
      HOLD:    state_d = empty ? IDLE : txe_act ? WRITE : HOLD;
      default: state_d = IDLE;
    endcase
    wr_d = (state_d == WRITE) ? WR_ACTIVE : !WR_ACTIVE;
    drive_d = state_d != IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wr_q <= !WR_ACTIVE;
      drive_q <= 1'b0;
      sent_q <= '0;
      pat_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      drive_q <= drive_d;
      sent_q <= sent_d;
      pat_q <= pat_d;
    end
  end
  assign adbus_io = drive_q ? head : {DATA_W{1'bz}};
  assign wr_o = wr_q;
  assign oe_o = !OE_ACTIVE;
  assign bytes_sent_o = sent_q;
  assign blinker_o = sent_q[BLINK_BIT];
endmodule

// File: tb/tb_ft245_sync_tx_streamer.sv
// tb_ft245_sync_tx_streamer: directed vectors plus FT-side byte capture for the FT245 sync transmit streamer.
module tb_ft245_sync_tx_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mode = 1'b0;
  logic txe = 1'b1;
  wire [7:0] adbus;
  logic wr, oe, blink;
  logic [4:0] level;
  logic [31:0] sent;
  int checks = 0;
  int errors = 0;
  logic [7:0] rx[$];

  ft245_sync_tx_streamer_if #(.DATA_W(8)) s_if ();
  pullup pu_adbus (adbus);

  ft245_sync_tx_streamer #(.DATA_W(8), .FIFO_DEPTH(16), .BLINK_BIT(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mode_i       (mode),
    .s            (s_if),
    .adbus_io     (adbus),
    .txe_i        (txe),
    .wr_o         (wr),
    .oe_o         (oe),
    .level_o      (level),
    .bytes_sent_o (sent),
    .blinker_o    (blink)
  );

  always #5 clk = ~clk;

  // FT-side model: takes a byte whenever WR# and TXE# are both low at the edge.
  always @(posedge clk) if (rst_n && !wr && !txe) rx.push_back(adbus);

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       txe;
    logic       exp_wr;
    logic [4:0] exp_level;
    logic [7:0] exp_bus;
    logic [31:0] exp_sent;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] rxat(input int i);
    return (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pushed, stall, first_block, lvl_block, bad;
    logic rdy, seen15, seen16;
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 5'd1, 8'hFF, 32'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 8'hA5, 32'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 8'hA5, 32'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'hFF, 32'd1};
    vecs[4]  = '{1'b1, 8'h21, 1'b0, 1'b1, 5'd1, 8'hFF, 32'd1};
    vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 5'd2, 8'h21, 32'd1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd2, 8'h21, 32'd1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd2, 8'h21, 32'd1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd2, 8'h21, 32'd1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 8'h22, 32'd2};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 5'd1, 8'h22, 32'd2};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 8'h22, 32'd2};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'hFF, 32'd3};

    s_if.valid = 1'b1;
    s_if.data = 8'h55;
    txe = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_wr", wr, 1);
    chk("rst_oe", oe, 1);
    chk("rst_bus", adbus, 8'hFF);
    chk("rst_ready", s_if.ready, 0);
    chk("rst_sent", sent, 0);
    chk("rst_level", level, 0);
    s_if.valid = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      s_if.valid = vecs[i].valid;
      s_if.data = vecs[i].data;
      txe = vecs[i].txe;
      tick();
      chk($sformatf("vec%0d_wr", i), wr, vecs[i].exp_wr);
      chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
      chk($sformatf("vec%0d_bus", i), adbus, vecs[i].exp_bus);
      chk($sformatf("vec%0d_sent", i), sent, vecs[i].exp_sent);
      chk($sformatf("vec%0d_ready", i), s_if.ready, 1);
    end
    chk("vec_rx", {rxat(0)[7:0], rxat(1)[7:0], rxat(2)[7:0]}, 24'hA52122);

    rx.delete();
    txe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_if.valid = 1'b1;
      s_if.data = 8'(8'h10 + i);
      tick();
    end
    s_if.valid = 1'b0;
    for (int c = 0; c < 30 && !(rx.size() == 8 && wr && level == 0); c++) tick();
    chk("burst_count", rx.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("burst_byte%0d", i), rxat(i), 32'(8'h10 + i));
    chk("burst_sent", sent, 11);
    chk("burst_level", level, 0);
    chk("burst_bus", adbus, 8'hFF);

    rx.delete();
    pushed = 0;
    stall = 0;
    for (int c = 0; c < 60 && !(rx.size() == 8 && wr && level == 0 && pushed == 8); c++) begin
      s_if.valid = pushed < 8;
      s_if.data = 8'(pushed);
      txe = rx.size() == 3 && stall < 3;
      if (txe) stall++;
      tick();
      if (s_if.valid) pushed++;
    end
    s_if.valid = 1'b0;
    txe = 1'b0;
    chk("stall_cycles", stall, 3);
    chk("stall_count", rx.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("stall_byte%0d", i), rxat(i), i);

    rx.delete();
    pushed = 0;
    first_block = -1;
    lvl_block = 0;
    for (int c = 0; c < 90 && !(pushed == 20 && rx.size() == 20 && wr && level == 0); c++) begin
      txe = c < 25;
      s_if.valid = pushed < 20;
      s_if.data = 8'(8'h40 + pushed);
      rdy = s_if.ready;
      if (s_if.valid && !rdy && first_block < 0) begin
        first_block = pushed;
        lvl_block = level;
      end
      tick();
      if (s_if.valid && rdy) pushed++;
    end
    s_if.valid = 1'b0;
    chk("bp_block_after", first_block, 16);
    chk("bp_block_level", lvl_block, 16);
    chk("bp_count", rx.size(), 20);
    for (int i = 0; i < 20; i++) chk($sformatf("bp_byte%0d", i), rxat(i), 32'(8'h40 + i));

    do_reset();
    rx.delete();
    mode = 1'b1;
    txe = 1'b0;
    seen15 = 1'b0;
    seen16 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (c == 10) chk("count_ready", s_if.ready, 0);
      if (sent == 15 && !seen15) begin
        seen15 = 1'b1;
        chk("blink_at15", blink, 0);
      end
      if (sent == 16 && !seen16) begin
        seen16 = 1'b1;
        chk("blink_at16", blink, 1);
      end
    end
    chk("blink_seen", {seen15, seen16}, 2'b11);
    bad = 0;
    foreach (rx[i]) if (rx[i] != 8'(i)) bad++;
    chk("count_contig_errs", bad, 0);
    chk("count_throughput", rx.size() >= 290, 1);
    chk("count_wrap", rxat(256), 0);

    mode = 1'b0;
    do_reset();
    rx.delete();
    pushed = 0;
    for (int c = 0; c < 30 && rx.size() < 2; c++) begin
      s_if.valid = pushed < 8;
      s_if.data = 8'(8'h30 + pushed);
      tick();
      if (s_if.valid) pushed++;
    end
    s_if.valid = 1'b0;
    chk("mid_pre_wr", wr, 0);
    chk("mid_pre_rx", rx.size(), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", wr, 1);
    chk("mid_rst_bus", adbus, 8'hFF);
    chk("mid_rst_level", level, 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_after_rx", rx.size(), 2);
    chk("mid_after_wr", wr, 1);
    chk("mid_after_level", level, 0);
    chk("mid_after_sent", sent, 0);
    chk("mid_after_bus", adbus, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
